// File: rtl/tl_conflict_monitor.sv
// tl_conflict_monitor
//   Independent safety checker for the 4-lane traffic light lamp drive.
//   Watches the four one-hot lamp vectors and latches the first violation:
//     1 illegal encoding, 2 conflicting non-red lanes, 3 illegal transition,
//     4 yellow timing, 5 all-red gap too short, 6 green timing.
//   A latched fault raises flash_req for the intersection fail-safe.
//   One clk cycle = one 100 ms controller tick.
// Ports:
//   clk          10 Hz tick clock
//   arstN        asynchronous active-low reset
//   tl_sig_arr   lamp vectors, [0]=lane A .. [3]=lane D (000 off,001 G,010 Y,100 R)
//   clr          synchronous clear of the latched fault; also disarms
//   armed        monitor has seen all four lanes red and is checking
//   fault        sticky fault flag
//   fault_code   first violation code (0 = none)
//   fault_lane   lane associated with fault_code
//   flash_req    all-red flash request (same as fault)
//   served_pulse one-cycle pulse on a legal G->Y
//   served_lane  lane of the last served_pulse (held between pulses)
module tl_conflict_monitor #(
  parameter int unsigned YEL_TICKS     = 30,
  parameter int unsigned ALLRED_TICKS  = 30,
  parameter int unsigned GRN_MIN_TICKS = 1,
  parameter int unsigned GRN_MAX_TICKS = 300,
  parameter int unsigned CNT_W         = 9
) (
  input  logic       clk,
  input  logic       arstN,
  input  logic [2:0] tl_sig_arr [4],
  input  logic       clr,
  output logic       armed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_lane,
  output logic       flash_req,
  output logic       served_pulse,
  output logic [1:0] served_lane
);

  localparam logic [2:0] L_OFF = 3'b000;
  localparam logic [2:0] L_G   = 3'b001;
  localparam logic [2:0] L_Y   = 3'b010;
  localparam logic [2:0] L_R   = 3'b100;

  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YEL_TICKS);
  localparam logic [CNT_W-1:0] AR_C   = CNT_W'(ALLRED_TICKS);
  localparam logic [CNT_W-1:0] GMIN_C = CNT_W'(GRN_MIN_TICKS);
  localparam logic [CNT_W-1:0] GMAX_C = CNT_W'(GRN_MAX_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       prev_q [4];
  logic [CNT_W-1:0] gy_cnt_q, gy_cnt_d;
  logic [CNT_W-1:0] ar_cnt_q, ar_cnt_d;
  logic [2:0]       code_q, code_d;
  logic [1:0]       lane_q, lane_d;
  logic             sp_q, sp_d;
  logic [1:0]       sl_q, sl_d;

  logic             any_lit, all_r, gy_any;
  logic [2:0]       gy_n;
  logic [1:0]       act_lane;
  logic [3:0]       viol [1:6];
  logic [6:1]       en;
  logic [3:0]       serve;
  logic             hit;
  logic [2:0]       hit_code;
  logic [1:0]       hit_lane;

  function automatic logic [1:0] lowest_lane(input logic [3:0] v);
    logic [1:0] r;
    logic       f;
    r = '0;
    f = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (v[i] && !f) begin
        r = 2'(i);
        f = 1'b1;
      end
    end
    return r;
  endfunction

  // Per-lane violation detection
  always_comb begin
    any_lit  = 1'b0;
    all_r    = 1'b1;
    gy_any   = 1'b0;
    gy_n     = '0;
    act_lane = '0;
    serve    = '0;
    for (int unsigned c = 1; c <= 6; c++) viol[c] = '0;

    for (int unsigned i = 0; i < 4; i++) begin
      if (tl_sig_arr[i] != L_OFF) any_lit = 1'b1;
      if (tl_sig_arr[i] != L_R) all_r = 1'b0;
      if (tl_sig_arr[i] == L_G || tl_sig_arr[i] == L_Y) begin
        if (!gy_any) act_lane = 2'(i);
        gy_any = 1'b1;
        gy_n   = gy_n + 3'd1;
      end
    end

    for (int unsigned i = 0; i < 4; i++) begin
      logic [2:0] cur, prv;
      cur = tl_sig_arr[i];
      prv = prev_q[i];
      viol[1][i] = !(cur inside {L_OFF, L_G, L_Y, L_R}) || (cur == L_OFF && any_lit);
      viol[2][i] = (gy_n > 3'd1) && (cur == L_G || cur == L_Y);
      viol[3][i] = !((cur == prv) ||
                     (prv == L_R && cur == L_G) ||
                     (prv == L_G && cur == L_Y) ||
                     (prv == L_Y && cur == L_R));
      // gy_cnt_q == YEL_C while still yellow means this sample is YEL+1
      viol[4][i] = (prv == L_Y) &&
                   ((cur == L_R && gy_cnt_q != YEL_C) ||
                    (cur == L_Y && gy_cnt_q >= YEL_C));
      viol[5][i] = (prv == L_R) && (cur == L_G) && (ar_cnt_q < AR_C);
      viol[6][i] = (prv == L_G) &&
                   ((cur == L_Y && gy_cnt_q < GMIN_C) ||
                    (cur == L_G && gy_cnt_q >= GMAX_C));
      serve[i]   = (prv == L_G) && (cur == L_Y);
    end
  end

  // Lowest code wins, then lowest lane within that code
  always_comb begin
    en[1]    = (state_q != S_FAULT);
    en[6:2]  = {5{state_q == S_ARMED}};
    hit      = 1'b0;
    hit_code = '0;
    hit_lane = '0;
    for (int unsigned c = 1; c <= 6; c++) begin
      if (!hit && en[c] && (|viol[c])) begin
        hit      = 1'b1;
        hit_code = 3'(c);
        hit_lane = lowest_lane(viol[c]);
      end
    end
  end

  // Next state, fault latch, served pulse
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    lane_d  = lane_q;
    sp_d    = 1'b0;
    sl_d    = sl_q;
    if (clr) begin
      state_d = S_IDLE;
      code_d  = '0;
      lane_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (hit) begin
            state_d = S_FAULT;
            code_d  = hit_code;
            lane_d  = hit_lane;
          end else if (all_r) begin
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (hit) begin
            state_d = S_FAULT;
            code_d  = hit_code;
            lane_d  = hit_lane;
          end else if (|serve) begin
            sp_d = 1'b1;
            sl_d = lowest_lane(serve);
          end
        end
        S_FAULT: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Duration counters run in every state so timing is valid the moment we arm
  always_comb begin
    if (!gy_any)
      gy_cnt_d = '0;
    else if (tl_sig_arr[act_lane] != prev_q[act_lane])
      gy_cnt_d = CNT_W'(1);
    else if (gy_cnt_q == '1)
      gy_cnt_d = gy_cnt_q;
    else
      gy_cnt_d = gy_cnt_q + CNT_W'(1);

    if (!all_r)
      ar_cnt_d = '0;
    else if (ar_cnt_q == '1)
      ar_cnt_d = ar_cnt_q;
    else
      ar_cnt_d = ar_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge arstN) begin
    if (!arstN) begin
      state_q  <= S_IDLE;
      for (int unsigned i = 0; i < 4; i++) prev_q[i] <= '0;
      gy_cnt_q <= '0;
      ar_cnt_q <= '0;
      code_q   <= '0;
      lane_q   <= '0;
      sp_q     <= 1'b0;
      sl_q     <= '0;
    end else begin
      state_q  <= state_d;
      for (int unsigned i = 0; i < 4; i++) prev_q[i] <= tl_sig_arr[i];
      gy_cnt_q <= gy_cnt_d;
      ar_cnt_q <= ar_cnt_d;
      code_q   <= code_d;
      lane_q   <= lane_d;
      sp_q     <= sp_d;
      sl_q     <= sl_d;
    end
  end

  assign armed        = (state_q == S_ARMED);
  assign fault        = (state_q == S_FAULT);
  assign flash_req    = (state_q == S_FAULT);
  assign fault_code   = code_q;
  assign fault_lane   = lane_q;
  assign served_pulse = sp_q;
  assign served_lane  = sl_q;

endmodule

// File: tb/tb_tl_conflict_monitor.sv
// Directed bench for tl_conflict_monitor.
module tb_tl_conflict_monitor;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] R   = 3'b100;

  logic       clk;
  logic       arstN;
  logic [2:0] sig [4];
  logic       clr;
  logic       armed, fault, flash_req, served_pulse;
  logic [2:0] fault_code;
  logic [1:0] fault_lane, served_lane;

  int errors = 0;
  int checks = 0;

  tl_conflict_monitor #(
    .YEL_TICKS(30),
    .ALLRED_TICKS(30),
    .GRN_MIN_TICKS(1),
    .GRN_MAX_TICKS(300),
    .CNT_W(9)
  ) dut (
    .clk(clk),
    .arstN(arstN),
    .tl_sig_arr(sig),
    .clr(clr),
    .armed(armed),
    .fault(fault),
    .fault_code(fault_code),
    .fault_lane(fault_lane),
    .flash_req(flash_req),
    .served_pulse(served_pulse),
    .served_lane(served_lane)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_sig(input logic [2:0] a, b, c, d);
    sig[0] = a; sig[1] = b; sig[2] = c; sig[3] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_fault(input string tag, input logic [2:0] code, input logic [1:0] lane);
    chk({tag, "_fault"}, fault, 1'b1);
    chk({tag, "_flash"}, flash_req, 1'b1);
    chk({tag, "_code"}, fault_code, code);
    chk({tag, "_lane"}, fault_lane, lane);
  endtask

  // Hold a vector n cycles, no fault expected; optional served pulse on first cycle
  task automatic hold(input logic [2:0] a, b, c, d, input int n,
                      input bit pulse_first, input logic [1:0] plane);
    set_sig(a, b, c, d);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("hold_fault", fault, 1'b0);
      chk("hold_served_pulse", served_pulse, (i == 0) && pulse_first);
      if (i == 0 && pulse_first) chk("hold_served_lane", served_lane, plane);
    end
  endtask

  task automatic do_clr(input logic [2:0] a, b, c, d);
    set_sig(a, b, c, d);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_fault", fault, 1'b0);
    chk("clr_code", fault_code, 3'd0);
    chk("clr_lane", fault_lane, 2'd0);
    chk("clr_armed", armed, 1'b0);
  endtask

  initial begin
    logic [2:0] v [4];

    // Reset
    arstN = 1'b0;
    clr   = 1'b0;
    set_sig(OFF, OFF, OFF, OFF);
    #2;
    chk("rst_armed", armed, 1'b0);
    chk("rst_fault", fault, 1'b0);
    chk("rst_code", fault_code, 3'd0);
    chk("rst_lane", fault_lane, 2'd0);
    chk("rst_flash", flash_req, 1'b0);
    chk("rst_served", served_pulse, 1'b0);
    chk("rst_served_lane", served_lane, 2'd0);
    #10 arstN = 1'b1;

    // Arm and run three legal rotations
    set_sig(R, R, R, R);
    tick();
    chk("arm_first_allr", armed, 1'b1);
    hold(R, R, R, R, 29, 1'b0, 2'd0);
    for (int r = 0; r < 3; r++) begin
      for (int l = 0; l < 4; l++) begin
        v[0] = R; v[1] = R; v[2] = R; v[3] = R;
        v[l] = G;
        hold(v[0], v[1], v[2], v[3], 300, 1'b0, 2'd0);
        v[l] = Y;
        hold(v[0], v[1], v[2], v[3], 30, 1'b1, 2'(l));
        hold(R, R, R, R, 30, 1'b0, 2'd0);
      end
    end
    chk("rot_armed", armed, 1'b1);

    // Green overrun on lane C
    hold(R, R, G, R, 300, 1'b0, 2'd0);
    tick();
    chk_fault("grn_max", 3'd6, 2'd2);
    set_sig(R, R, Y, R);
    tick();
    tick();
    chk("grn_max_sticky_code", fault_code, 3'd6);
    chk("grn_max_no_serve", served_pulse, 1'b0);
    do_clr(R, R, R, R);

    // Yellow too short on lane B
    hold(R, R, R, R, 30, 1'b0, 2'd0);
    chk("rearm", armed, 1'b1);
    hold(R, G, R, R, 10, 1'b0, 2'd0);
    hold(R, Y, R, R, 29, 1'b1, 2'd1);
    set_sig(R, R, R, R);
    tick();
    chk_fault("yel_short", 3'd4, 2'd1);
    do_clr(R, R, R, R);

    // Yellow too long on lane B
    hold(R, R, R, R, 30, 1'b0, 2'd0);
    hold(R, G, R, R, 10, 1'b0, 2'd0);
    hold(R, Y, R, R, 30, 1'b1, 2'd1);
    tick();
    chk_fault("yel_long", 3'd4, 2'd1);
    do_clr(R, R, R, R);

    // Conflict: lane A green while lane D still yellow
    hold(R, R, R, R, 30, 1'b0, 2'd0);
    hold(R, R, R, G, 10, 1'b0, 2'd0);
    hold(R, R, R, Y, 5, 1'b1, 2'd3);
    set_sig(G, R, R, Y);
    tick();
    chk_fault("conflict", 3'd2, 2'd0);

    // All-red gap of only 10 cycles
    do_clr(R, R, R, R);
    hold(R, R, R, R, 9, 1'b0, 2'd0);
    chk("gap_armed", armed, 1'b1);
    set_sig(G, R, R, R);
    tick();
    chk_fault("allred_gap", 3'd5, 2'd0);

    // Illegal encoding in IDLE
    do_clr(OFF, OFF, OFF, OFF);
    set_sig(R, 3'b011, R, R);
    tick();
    chk_fault("idle_illegal", 3'd1, 2'd1);
    do_clr(R, R, R, R);
    set_sig(R, R, R, R);
    tick();
    chk("rearm_after_clr", armed, 1'b1);

    // clr beats a same-cycle violation
    do_clr(R, 3'b011, R, R);

    // Illegal encoding beats illegal transition in the same cycle
    hold(R, R, R, R, 30, 1'b0, 2'd0);
    hold(R, R, R, G, 5, 1'b0, 2'd0);
    set_sig(3'b110, R, R, R);
    tick();
    chk_fault("prio", 3'd1, 2'd0);

    // Asynchronous reset mid-cycle
    #3 arstN = 1'b0;
    #1;
    chk("arst_fault", fault, 1'b0);
    chk("arst_code", fault_code, 3'd0);
    chk("arst_lane", fault_lane, 2'd0);
    chk("arst_flash", flash_req, 1'b0);
    chk("arst_armed", armed, 1'b0);
    #2 arstN = 1'b1;
    set_sig(OFF, OFF, OFF, OFF);
    tick();
    chk("post_rst_off_armed", armed, 1'b0);
    set_sig(R, R, R, R);
    tick();
    chk("post_rst_rearm", armed, 1'b1);
    chk("post_rst_fault", fault, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tl_conflict_monitor.md
Name: tl_conflict_monitor

Overview:
- Independent safety checker on the lamp-drive side of the 4-lane traffic light controller.
- Reads the four 3-bit one-hot lamp vectors the controller drives and checks:
  - each lamp encoding is legal;
  - no two lanes are ever non-red at once;
  - each lane follows the G->Y->R sequence;
  - yellow, all-red and green durations stay within limits.
- On the first violation it latches a fault code and the offending lane, and raises a flash request for the intersection fail-safe.
- Runs on the same 10 Hz tick clock as the controller: 1 cycle = 100 ms.

Parameters:
- YEL_TICKS, 30, exact required yellow duration in cycles (3 s).
- ALLRED_TICKS, 30, minimum all-red gap before any green, in cycles (3 s).
- GRN_MIN_TICKS, 1, minimum green duration in cycles.
- GRN_MAX_TICKS, 300, maximum green duration in cycles (30 s).
- CNT_W, 9, width of the duration counters; must hold GRN_MAX_TICKS+1.

Ports:
- clk, input, 1, 10 Hz system clock.
- arstN, input, 1, asynchronous active-low reset.
- tl_sig_arr, input, 4 x 3 (unpacked array [4] of logic [2:0]), lamp vectors.
  - Element 0 = lane A … element 3 = lane D.
  - Encoding: 000 ALLOFF, 001 G, 010 Y, 100 R.
- clr, input, 1, synchronous clear of the latched fault; also disarms the monitor.
- armed, output, 1, high once the monitor has seen all four lanes red simultaneously.
- fault, output, 1, sticky fault flag.
- fault_code, output, 3, first-violation code (0 = none).
- fault_lane, output, 2, lane index associated with fault_code.
- flash_req, output, 1, equals fault; drives all-red flash in the fail-safe.
- served_pulse, output, 1, one-cycle pulse when a lane completes a legal green (G->Y).
- served_lane, output, 2, lane index for served_pulse; holds its value between pulses.

Behaviour:
- Reset (arstN low, asynchronous): every output 0, all counters 0, prev-state registers 0, state IDLE.
- All checks use registered outputs. A violating vector sampled at posedge n gives fault=1 after posedge n, i.e. one cycle of latency.
- States:
  - IDLE -> ARMED when all four lanes = R in the same cycle and no fault is latched.
  - ARMED -> FAULT on any violation.
  - FAULT holds until clr or reset.
  - clr in any state -> IDLE with fault/code/lane cleared. clr has priority over a same-cycle violation.
- Check active in IDLE and ARMED (code 1, illegal encoding): a lane value not in {000,001,010,100}, or a mix of ALLOFF and lit lanes in one cycle. All four lanes ALLOFF is legal.
- Checks active only in ARMED:
  - code 2, conflict: more than one lane is G or Y in the same cycle.
  - code 3, illegal transition: any lane change other than R->G, G->Y or Y->R. Also any lane going ALLOFF while armed.
  - code 4, yellow timing: on Y->R, the lane's yellow count != YEL_TICKS. Also yellow count reaching YEL_TICKS+1.
  - code 5, all-red gap: on R->G, the preceding consecutive all-red count < ALLRED_TICKS.
  - code 6, green timing: on G->Y, green count < GRN_MIN_TICKS. Also green count reaching GRN_MAX_TICKS+1, flagged while still in G.
- Simultaneous violations: lowest code wins. Within one code, the lowest lane index wins.
- The first fault is sticky; later violations do not overwrite code or lane.
- Counters:
  - One green/yellow counter for the single active lane; loads 1 on entry to G or Y and increments each cycle the lane holds.
  - One all-red counter; increments while all lanes are R and resets to 0 on any non-red.
  - All counters saturate at 2^CNT_W-1 (no wrap).
- served_pulse fires on a legal G->Y only (no fault raised that cycle), with served_lane = that lane. Suppressed in IDLE and FAULT.
- Asynchronous reset mid-cycle: outputs clear immediately. The monitor then re-arms only after a fresh all-red vector.

Test Plan:
- Reset, then all R for 30 cycles, lane A G for 300, Y for 30, R for 30, lane B G … -> armed=1 after the first all-R cycle; fault stays 0 for 3 full rotations; served_pulse on each G->Y with served_lane 0,1,2,3 in order.
- Armed; lane C held G for 301 cycles -> fault=1, fault_code=6, fault_lane=2 one cycle after the 301st G sample; flash_req=1; the later Y does not change the code.
- Armed; lane B Y for 29 cycles, then R -> fault_code=4, fault_lane=1. Repeat with Y for 31 cycles -> code 4 raised at the 31st Y sample.
- Armed; lane A G while lane D still Y (same cycle) -> fault_code=2. Separately, lane A R->G after only 10 all-red cycles -> fault_code=5, fault_lane=0.
- IDLE; lane B = 011 -> fault_code=1, fault_lane=1. Then clr=1 for one cycle -> fault=0, code=0, armed=0; re-arms on the next all-R cycle.
- Armed; lane D goes G->R directly and lane A shows 110 in the same cycle -> fault_code=1, fault_lane=0 (priority). Then arstN pulsed low mid-cycle -> all outputs 0 immediately.
